z16_alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared Z16 16-bit ALU. Accepts operations from two independent requesters over valid/ready handshakes, grants the ALU round-robin, drives its operand/control inputs from registered values, and captures and returns the result to the winning requester over a response handshake. It traps divide-by-zero before the ALU's undefined result reaches a requester.

---
 rtl/z16_alu_arbiter.sv | 118 +++++++++++
 tb/tb_z16_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z16_alu_arbiter.sv
// rtl/z16_alu_arbiter.sv - two-requester round-robin arbiter and sequencer for the shared Z16 ALU
module z16_alu_arbiter #(
  parameter logic [15:0] DIV_ZERO_VALUE = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid_0,
  input  logic        i_req_valid_1,
  output logic        o_req_ready_0,
  output logic        o_req_ready_1,
  input  logic [15:0] i_req_a_0,
  input  logic [15:0] i_req_a_1,
  input  logic [15:0] i_req_b_0,
  input  logic [15:0] i_req_b_1,
  input  logic [3:0]  i_req_ctrl_0,
  input  logic [3:0]  i_req_ctrl_1,
  output logic        o_rsp_valid_0,
  output logic        o_rsp_valid_1,
  input  logic        i_rsp_ready_0,
  input  logic        i_rsp_ready_1,
  output logic [15:0] o_rsp_data_0,
  output logic [15:0] o_rsp_data_1,
  output logic        o_rsp_err_0,
  output logic        o_rsp_err_1,
  output logic [15:0] o_alu_a,
  output logic [15:0] o_alu_b,
  output logic [3:0]  o_alu_ctrl,
  input  logic [15:0] i_alu_data,
  output logic        o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_ctrl;
  logic        grant;
  logic        rr_ptr;
  logic [15:0] result;
  logic        err;

  logic any_valid;
  logic winner;
  logic accept;
  logic rsp_active;
  logic rsp_taken;

  // Lone requester wins outright; rr_ptr only breaks ties.
  always_comb begin
    any_valid  = i_req_valid_0 | i_req_valid_1;
    winner     = (i_req_valid_0 & i_req_valid_1) ? rr_ptr : i_req_valid_1;
    accept     = (state == ST_IDLE) && any_valid && !i_rst;
    rsp_active = (state == ST_RESP) && !i_rst;
    rsp_taken  = grant ? i_rsp_ready_1 : i_rsp_ready_0;
  end

  assign o_req_ready_0 = accept && !winner;
  assign o_req_ready_1 = accept && winner;

  assign o_rsp_valid_0 = rsp_active && !grant;
  assign o_rsp_valid_1 = rsp_active && grant;
  assign o_rsp_data_0  = result;
  assign o_rsp_data_1  = result;
  assign o_rsp_err_0   = err;
  assign o_rsp_err_1   = err;

  assign o_alu_a    = op_a;
  assign o_alu_b    = op_b;
  assign o_alu_ctrl = op_ctrl;
  assign o_busy     = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      op_a    <= 16'h0000;
      op_b    <= 16'h0000;
      op_ctrl <= 4'h0;
      grant   <= 1'b0;
      rr_ptr  <= 1'b0;
      result  <= 16'h0000;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            op_a    <= winner ? i_req_a_1 : i_req_a_0;
            op_b    <= winner ? i_req_b_1 : i_req_b_0;
            op_ctrl <= winner ? i_req_ctrl_1 : i_req_ctrl_0;
            grant   <= winner;
            rr_ptr  <= ~winner;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The ALU's divide-by-zero output is undefined, so it never reaches a requester.
          if (op_ctrl == 4'h3 && op_a == 16'h0000) begin
            result <= DIV_ZERO_VALUE;
            err    <= 1'b1;
          end else begin
            result <= i_alu_data;
            err    <= 1'b0;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_taken) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z16_alu_arbiter.sv
// tb/tb_z16_alu_arbiter.sv - scoreboard bench for z16_alu_arbiter with a behavioural ALU
module tb_z16_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy0, rdy1;
  logic [15:0] a0, a1, b0, b1;
  logic [3:0]  c0, c1;
  logic        rv0, rv1, rr0, rr1;
  logic [15:0] d0, d1;
  logic        e0, e1;
  logic [15:0] alu_a, alu_b, alu_data;
  logic [3:0]  alu_ctrl;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {logic [15:0] a; logic [15:0] b; logic [3:0] ctrl;} op_t;
  typedef struct {int port; logic [15:0] data; logic err;} exp_t;

  op_t  q0[$];
  op_t  q1[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  z16_alu_arbiter #(.DIV_ZERO_VALUE(16'hFFFF)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid_0(v0), .i_req_valid_1(v1),
    .o_req_ready_0(rdy0), .o_req_ready_1(rdy1),
    .i_req_a_0(a0), .i_req_a_1(a1),
    .i_req_b_0(b0), .i_req_b_1(b1),
    .i_req_ctrl_0(c0), .i_req_ctrl_1(c1),
    .o_rsp_valid_0(rv0), .o_rsp_valid_1(rv1),
    .i_rsp_ready_0(rr0), .i_rsp_ready_1(rr1),
    .o_rsp_data_0(d0), .o_rsp_data_1(d1),
    .o_rsp_err_0(e0), .o_rsp_err_1(e1),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
    .i_alu_data(alu_data), .o_busy(busy)
  );

  // Behavioural Z16 ALU; divide-by-zero returns junk so a missing trap is visible.
  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c);
    logic [31:0] p;
    p = a * b;
    case (c)
      4'h0:    return a + b;
      4'h1:    return b - a;
      4'h2:    return p[15:0];
      4'h3:    return (a == 16'h0) ? 16'hDEAD : b / a;
      4'h4:    return a & b;
      4'h5:    return a | b;
      4'h6:    return a ^ b;
      default: return ~(a ^ b) + {12'h000, c};
    endcase
  endfunction

  assign alu_data = alu_model(alu_a, alu_b, alu_ctrl);

  function automatic exp_t expect_of(input int port, input op_t o);
    exp_t r;
    r.port = port;
    if (o.ctrl == 4'h3 && o.a == 16'h0) begin
      r.data = 16'hFFFF;
      r.err  = 1'b1;
    end else begin
      r.data = alu_model(o.a, o.b, o.ctrl);
      r.err  = 1'b0;
    end
    return r;
  endfunction

  task automatic load(input int k);
    op_t o;
    if (k == 0) begin
      if (q0.size() > 0) begin
        o = q0.pop_front(); v0 = 1'b1; a0 = o.a; b0 = o.b; c0 = o.ctrl;
      end else v0 = 1'b0;
    end else begin
      if (q1.size() > 0) begin
        o = q1.pop_front(); v1 = 1'b1; a1 = o.a; b1 = o.b; c1 = o.ctrl;
      end else v1 = 1'b0;
    end
  endtask

  // One clock: note accepts and response handshakes before the edge, refill requesters after it.
  task automatic step(output bit got, output int port, output logic [15:0] data, output logic err);
    bit acc0, acc1;
    #1;
    acc0 = v0 && rdy0;
    acc1 = v1 && rdy1;
    got = 1'b0; port = -1; data = 16'h0; err = 1'b0;
    if (rv0 && rr0) begin
      got = 1'b1; port = 0; data = d0; err = e0;
    end else if (rv1 && rr1) begin
      got = 1'b1; port = 1; data = d1; err = e1;
    end
    @(posedge clk);
    #1;
    if (acc0) load(0);
    if (acc1) load(1);
  endtask

  task automatic do_reset;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    q0.delete(); q1.delete(); sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;
    a0 = 16'h1111; b0 = 16'h2222; c0 = 4'h0; a1 = 16'h3333; b1 = 16'h4444; c1 = 4'h1;
    @(posedge clk);
    #1;
    n_cmp++; if ({rdy0, rdy1} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", {rdy0, rdy1}); end
    n_cmp++; if ({rv0, rv1} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", {rv0, rv1}); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({alu_a, alu_b, alu_ctrl} !== 36'h0) begin n_fail++; $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_a, alu_b, alu_ctrl); end
    n_cmp++; if ({d0, e0} !== 17'h0) begin n_fail++; $display("FAIL reset_result: got %h %b want 0000 0", d0, e0); end
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_op;
    bit got; int p; logic [15:0] d; logic e; exp_t ex;
    do_reset();
    rr0 = 1'b1;
    q0.push_back('{a: 16'd3, b: 16'd5, ctrl: 4'h0});
    sb.push_back('{port: 0, data: 16'h0008, err: 1'b0});
    load(0);
    #1;
    n_cmp++; if ({rdy0, rdy1} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {rdy0, rdy1}); end
    step(got, p, d, e);
    n_cmp++; if ({busy, rv0, rv1} !== 3'b100) begin n_fail++; $display("FAIL single_exec_flags: got %b want 100", {busy, rv0, rv1}); end
    n_cmp++; if ({alu_a, alu_b, alu_ctrl} !== {16'd3, 16'd5, 4'h0}) begin n_fail++; $display("FAIL single_alu_drive: got %h %h %h want 0003 0005 0", alu_a, alu_b, alu_ctrl); end
    step(got, p, d, e);
    ex = sb.pop_front();
    n_cmp++; if ({rv0, rv1} !== 2'b10) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 10", {rv0, rv1}); end
    n_cmp++; if ({d0, e0} !== {ex.data, ex.err}) begin n_fail++; $display("FAIL single_rsp_data: got %h %b want %h %b", d0, e0, ex.data, ex.err); end
    step(got, p, d, e);
    n_cmp++; if ({busy, rv0} !== 2'b00) begin n_fail++; $display("FAIL single_back_idle: got %b want 00", {busy, rv0}); end
  endtask

  task automatic test_contention;
    bit got; int p; logic [15:0] d; logic e; exp_t ex; int seen;
    do_reset();
    rr0 = 1'b1; rr1 = 1'b1;
    q0.push_back('{a: 16'd2, b: 16'd9, ctrl: 4'h1});
    q1.push_back('{a: 16'h00FF, b: 16'h0F0F, ctrl: 4'h4});
    q0.push_back('{a: 16'h1234, b: 16'h0001, ctrl: 4'h0});
    q1.push_back('{a: 16'h00F0, b: 16'h0F00, ctrl: 4'h5});
    sb.push_back('{port: 0, data: 16'h0007, err: 1'b0});
    sb.push_back('{port: 1, data: 16'h000F, err: 1'b0});
    sb.push_back('{port: 0, data: 16'h1235, err: 1'b0});
    sb.push_back('{port: 1, data: 16'h0FF0, err: 1'b0});
    load(0); load(1);
    #1;
    n_cmp++; if ({rdy0, rdy1} !== 2'b10) begin n_fail++; $display("FAIL contention_first_grant: got %b want 10", {rdy0, rdy1}); end
    seen = 0;
    for (int c = 0; c < 40 && seen < 4; c++) begin
      step(got, p, d, e);
      if (got) begin
        ex = sb.pop_front(); seen++;
        n_cmp++;
        if (p !== ex.port || d !== ex.data || e !== ex.err) begin
          n_fail++; $display("FAIL contention_rsp%0d: got port %0d data %h err %b want port %0d data %h err %b", seen, p, d, e, ex.port, ex.data, ex.err);
        end
      end
    end
    n_cmp++; if (seen != 4) begin n_fail++; $display("FAIL contention_timeout: got %0d responses want 4", seen); end
  endtask

  task automatic test_div_zero;
    bit got; int p; logic [15:0] d; logic e; exp_t ex; int seen;
    do_reset();
    rr0 = 1'b1; rr1 = 1'b1;
    q0.push_back('{a: 16'd0, b: 16'd100, ctrl: 4'h3});
    q0.push_back('{a: 16'd4, b: 16'd100, ctrl: 4'h3});
    q1.push_back('{a: 16'h0100, b: 16'h0100, ctrl: 4'h2});
    sb.push_back('{port: 0, data: 16'hFFFF, err: 1'b1});
    sb.push_back('{port: 1, data: 16'h0000, err: 1'b0});
    sb.push_back('{port: 0, data: 16'd25, err: 1'b0});
    load(0); load(1);
    seen = 0;
    for (int c = 0; c < 30 && seen < 3; c++) begin
      step(got, p, d, e);
      if (got) begin
        ex = sb.pop_front(); seen++;
        n_cmp++;
        if (p !== ex.port || d !== ex.data || e !== ex.err) begin
          n_fail++; $display("FAIL divzero_mulwrap_rsp%0d: got port %0d data %h err %b want port %0d data %h err %b", seen, p, d, e, ex.port, ex.data, ex.err);
        end
      end
    end
    n_cmp++; if (seen != 3) begin n_fail++; $display("FAIL divzero_timeout: got %0d responses want 3", seen); end
  endtask

  task automatic test_backpressure;
    bit got; int p; logic [15:0] d; logic e; exp_t ex; int seen;
    do_reset();
    rr0 = 1'b1; rr1 = 1'b0;
    q1.push_back('{a: 16'd10, b: 16'd20, ctrl: 4'h0});
    sb.push_back('{port: 1, data: 16'd30, err: 1'b0});
    load(1);
    for (int c = 0; c < 10 && !rv1; c++) step(got, p, d, e);
    n_cmp++; if (rv1 !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_arrive: got %b want 1", rv1); end
    q0.push_back('{a: 16'h00F0, b: 16'h0F00, ctrl: 4'h5});
    sb.push_back('{port: 0, data: 16'h0FF0, err: 1'b0});
    load(0);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if ({rv1, d1, e1, rdy0, rdy1} !== {1'b1, 16'd30, 1'b0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold_c%0d: got valid %b data %h err %b rdy %b%b want 1 001e 0 00", c, rv1, d1, e1, rdy0, rdy1);
      end
      step(got, p, d, e);
    end
    rr1 = 1'b1;
    step(got, p, d, e);
    ex = sb.pop_front();
    n_cmp++; if (!got || p !== ex.port || d !== ex.data || e !== ex.err) begin n_fail++; $display("FAIL bp_release: got hs %b port %0d data %h want port %0d data %h", got, p, d, ex.port, ex.data); end
    n_cmp++; if ({busy, rdy0} !== 2'b01) begin n_fail++; $display("FAIL bp_next_accept: got busy %b rdy0 %b want 0 1", busy, rdy0); end
    seen = 0;
    for (int c = 0; c < 10 && seen < 1; c++) begin
      step(got, p, d, e);
      if (got) begin
        ex = sb.pop_front(); seen++;
        n_cmp++;
        if (p !== ex.port || d !== ex.data || e !== ex.err) begin
          n_fail++; $display("FAIL bp_followup: got port %0d data %h err %b want port %0d data %h err %b", p, d, e, ex.port, ex.data, ex.err);
        end
      end
    end
    n_cmp++; if (seen != 1) begin n_fail++; $display("FAIL bp_timeout: got %0d responses want 1", seen); end
  endtask

  task automatic test_reset_mid_op;
    bit got; int p; logic [15:0] d; logic e; exp_t ex; int seen;
    do_reset();
    rr0 = 1'b1; rr1 = 1'b1;
    q1.push_back('{a: 16'd7, b: 16'd8, ctrl: 4'h0});
    load(1);
    step(got, p, d, e);
    n_cmp++; if ({busy, alu_a} !== {1'b1, 16'd7}) begin n_fail++; $display("FAIL midop_in_exec: got busy %b alu_a %h want 1 0007", busy, alu_a); end
    rst = 1'b1;
    step(got, p, d, e);
    rst = 1'b0;
    n_cmp++; if ({busy, rv0, rv1} !== 3'b000) begin n_fail++; $display("FAIL midop_after_reset: got %b want 000", {busy, rv0, rv1}); end
    step(got, p, d, e);
    n_cmp++; if ({rv0, rv1} !== 2'b00) begin n_fail++; $display("FAIL midop_dropped: got %b want 00", {rv0, rv1}); end
    q0.push_back('{a: 16'd1, b: 16'd1, ctrl: 4'h6});
    q1.push_back('{a: 16'd1, b: 16'd3, ctrl: 4'h1});
    sb.push_back('{port: 0, data: 16'h0000, err: 1'b0});
    sb.push_back('{port: 1, data: 16'h0002, err: 1'b0});
    load(0); load(1);
    #1;
    n_cmp++; if ({rdy0, rdy1} !== 2'b10) begin n_fail++; $display("FAIL midop_rr_reset: got %b want 10", {rdy0, rdy1}); end
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      step(got, p, d, e);
      if (got) begin
        ex = sb.pop_front(); seen++;
        n_cmp++;
        if (p !== ex.port || d !== ex.data || e !== ex.err) begin
          n_fail++; $display("FAIL midop_rsp%0d: got port %0d data %h err %b want port %0d data %h err %b", seen, p, d, e, ex.port, ex.data, ex.err);
        end
      end
    end
    n_cmp++; if (seen != 2) begin n_fail++; $display("FAIL midop_timeout: got %0d responses want 2", seen); end
  endtask

  task automatic test_random_mix;
    bit got; int p; logic [15:0] d; logic e; exp_t ex; int seen; int n;
    op_t o; op_t k0[$]; op_t k1[$]; logic rr; logic w;
    do_reset();
    rr0 = 1'b1; rr1 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      o.a    = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      o.b    = 16'($urandom);
      o.ctrl = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) q0.push_back(o); else q1.push_back(o);
    end
    k0 = q0; k1 = q1; rr = 1'b0;
    while (k0.size() > 0 || k1.size() > 0) begin
      w = (k0.size() > 0 && k1.size() > 0) ? rr : (k1.size() > 0);
      o = w ? k1.pop_front() : k0.pop_front();
      sb.push_back(expect_of(w ? 1 : 0, o));
      rr = ~w;
    end
    n = sb.size();
    load(0); load(1);
    seen = 0;
    for (int c = 0; c < 100 && seen < n; c++) begin
      step(got, p, d, e);
      if (got) begin
        ex = sb.pop_front(); seen++;
        n_cmp++;
        if (p !== ex.port || d !== ex.data || e !== ex.err) begin
          n_fail++; $display("FAIL random_rsp%0d: got port %0d data %h err %b want port %0d data %h err %b", seen, p, d, e, ex.port, ex.data, ex.err);
        end
      end
    end
    n_cmp++; if (seen != n) begin n_fail++; $display("FAIL random_timeout: got %0d responses want %0d", seen, n); end
  endtask

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    a0 = 16'h0; b0 = 16'h0; c0 = 4'h0; a1 = 16'h0; b1 = 16'h0; c1 = 4'h0;
    test_reset();
    test_single_op();
    test_contention();
    test_div_zero();
    test_backpressure();
    test_reset_mid_op();
    test_random_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
